// File: rtl/mem_sram_stage.sv
// Memory stage: turns a 32-bit LDR/STR from the execute stage into two
// 16-bit accesses on an external asynchronous SRAM, and holds the upstream
// pipeline frozen (ready=0) until both halves are done.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; ready=1 unless a request is present
// LOW    | low halfword access (addr LSB=0), held WAIT_CYCLES+1 cycles
// HIGH   | high halfword access (addr LSB=1), held WAIT_CYCLES+1 cycles
// DONE   | one cycle with ready=1; the pipeline advances on this edge
module mem_sram_stage #(
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int            CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_w_q, op_w_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic               req;
  logic               cnt_last;
  logic [31:0]        offs;
  logic [SRAM_AW-2:0] word_in;
  logic               unused_offs_bits;

  assign req      = mem_r_en | mem_w_en;
  assign cnt_last = (cnt_q == CNT_LAST);
  // Byte offset from the SRAM window base; wraps modulo 2^32, and only the
  // word bits that fit the SRAM survive (out-of-range addresses alias).
  assign offs             = alu_result - 32'(ADDR_BASE);
  assign word_in          = offs[SRAM_AW:2];
  assign unused_offs_bits = ^{offs[31:SRAM_AW+1], offs[1:0]};

  assign ready       = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  // Next-state and registered-output decode; pad outputs are computed one
  // cycle ahead so they are glitch-free registers during each half.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_w_d   = op_w_q;
    word_d   = word_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    oe_d     = oe_q;
    we_n_d   = we_n_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_LOW;
          cnt_d    = '0;
          op_w_d   = mem_w_en;
          word_d   = word_in;
          data_d   = val_rm;
          addr_d   = {word_in, 1'b0};
          dq_out_d = val_rm[15:0];
          oe_d     = mem_w_en;
          we_n_d   = !mem_w_en;
        end
      end
      S_LOW: begin
        if (cnt_last) begin
          state_d  = S_HIGH;
          cnt_d    = '0;
          addr_d   = {word_q, 1'b1};
          dq_out_d = data_q[31:16];
          if (!op_w_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
          if (!op_w_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset releases the SRAM strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_w_q   <= 1'b0;
      word_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_w_q   <= op_w_d;
      word_q   <= word_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
    end
  end

endmodule
